// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter sharing one combinational ALU between two valid/ready requesters
module alu_scheduler #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OP_W-1:0]  req_op0,
  input  logic [OP_W-1:0]  req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state;
  logic   r_ptr;
  logic   r_owner;
  logic   w_any;
  logic   w_grant;
  logic   w_illegal;
  assign w_any     = |req_valid;
  assign w_grant   = req_valid[r_ptr] ? r_ptr : ~r_ptr;
  // gated by rst_n so nothing is offered while reset is held
  assign req_ready = (rst_n && r_state == IDLE && w_any) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_illegal = !(alu_op == OP_W'(0) || alu_op == OP_W'(1) || alu_op == OP_W'(2) || alu_op == OP_W'(6));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          alu_a   <= w_grant ? req_a1 : req_a0;
          alu_b   <= w_grant ? req_b1 : req_b0;
          alu_op  <= w_grant ? req_op1 : req_op0;
          r_owner <= w_grant;
          r_ptr   <= ~w_grant;
          r_state <= EXEC;
        end
        EXEC: begin
          rsp_result <= w_illegal ? '0 : alu_result;
          rsp_zero   <= !w_illegal && alu_zero;
          rsp_err    <= w_illegal;
          rsp_valid  <= r_owner ? 2'b10 : 2'b01;
          r_state    <= RESP;
        end
        RESP: if (rsp_ready[r_owner]) begin
          rsp_valid <= 2'b00;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: transaction-level scoreboard with random and directed traffic for alu_scheduler
module tb_alu_scheduler;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  req_valid = 0;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = 0, req_a1 = 0, req_b0 = 0, req_b1 = 0;
  logic [3:0]  req_op0 = 0, req_op1 = 0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  alu_scheduler #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero)
  );
  always #5 clk = ~clk;
  // external ALU; illegal codes yield a^b so the scheduler's forcing to zero is visible
  always_comb begin
    alu_result = alu_op == 4'd0 ? alu_a & alu_b : alu_op == 4'd1 ? alu_a | alu_b :
                 alu_op == 4'd2 ? alu_a + alu_b : alu_op == 4'd6 ? alu_a - alu_b : alu_a ^ alu_b;
    alu_zero = alu_result == 0;
  end
  typedef struct {logic own; logic [31:0] res; logic z; logic e; int acc;} rsp_t;
  rsp_t        q[$];
  logic        p_v[2];
  logic [31:0] p_a[2], p_b[2];
  logic [3:0]  p_op[2];
  logic        m_ptr;
  int          cyc, n_chk, n_err;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic rsp_t expect_rsp(logic g, logic [31:0] a, logic [31:0] b, logic [3:0] op, int c);
    rsp_t r;
    r.own = g;
    r.acc = c;
    r.e   = !(op inside {4'd0, 4'd1, 4'd2, 4'd6});
    r.res = r.e ? 32'd0 : op == 4'd0 ? a & b : op == 4'd1 ? a | b : op == 4'd2 ? a + b : a - b;
    r.z   = !r.e && r.res == 0;
    return r;
  endfunction
  task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    p_v[i] = 1; p_a[i] = a; p_b[i] = b; p_op[i] = op;
  endtask
  // one clock: drive pending requests, compare against the transaction model, advance
  task automatic step();
    logic       g;
    logic [1:0] exp_rdy, exp_v;
    req_valid = {p_v[1], p_v[0]};
    req_a0 = p_a[0]; req_b0 = p_b[0]; req_op0 = p_op[0];
    req_a1 = p_a[1]; req_b1 = p_b[1]; req_op1 = p_op[1];
    #1;
    g = req_valid[m_ptr] ? m_ptr : ~m_ptr;
    exp_rdy = (q.size() == 0 && req_valid != 0) ? (2'b01 << g) : 2'b00;
    check("req_ready", req_ready, exp_rdy);
    if (q.size() != 0) begin
      exp_v = (cyc - q[0].acc >= 2) ? (2'b01 << q[0].own) : 2'b00;
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v != 0) begin
        check("rsp_result", rsp_result, q[0].res);
        check("rsp_zero", rsp_zero, q[0].z);
        check("rsp_err", rsp_err, q[0].e);
        if (rsp_ready[q[0].own]) void'(q.pop_front());
      end
    end else check("rsp_valid idle", rsp_valid, 2'b00);
    if ((req_ready & req_valid) != 0) begin
      q.push_back(expect_rsp(g, p_a[g], p_b[g], p_op[g], cyc));
      m_ptr = ~g;
      p_v[g] = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask
  task automatic drain();
    rsp_ready = 2'b11;
    for (int i = 0; i < 60 && (q.size() != 0 || p_v[0] || p_v[1]); i++) step();
    check("drain", q.size() + int'(p_v[0]) + int'(p_v[1]), 0);
  endtask
  initial begin
    p_v[0] = 0; p_v[1] = 0;
    p_a = '{0, 0}; p_b = '{0, 0}; p_op = '{0, 0};
    m_ptr = 0; cyc = 0; n_chk = 0; n_err = 0;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", req_ready, 2'b00);
    check("reset rsp_valid", rsp_valid, 2'b00);
    check("reset alu_a", alu_a, 0);
    check("reset alu_b", alu_b, 0);
    check("reset alu_op", alu_op, 0);
    check("reset rsp_result", {rsp_result, rsp_zero, rsp_err}, 0);
    issue(0, 45, 67, 4'd0);
    issue(1, 33, 33, 4'd6);
    rst_n = 1;
    drain();
    foreach (p_op[k]) begin end
    for (int k = 1; k < 4; k++) begin
      issue(0, 45, 67, k == 1 ? 4'd1 : k == 2 ? 4'd2 : 4'd6);
      drain();
    end
    for (int k = 0; k < 14; k++) begin
      if (!p_v[0]) issue(0, 67, 45, 4'd2);
      if (!p_v[1]) issue(1, 67, 45, 4'd6);
      step();
    end
    drain();
    issue(0, 32'hDEAD_0000, 32'h0000_BEEF, 4'd1);
    step();
    issue(1, 5, 9, 4'd2);
    rsp_ready = 2'b00;
    repeat (7) step();
    rsp_ready = 2'b11;
    drain();
    issue(0, 12, 34, 4'hF);
    drain();
    issue(1, 7, 7, 4'h5);
    step();
    check("alu_op in exec", alu_op, 4'h5);
    rst_n = 0;
    #1;
    check("mid reset rsp_valid", rsp_valid, 2'b00);
    check("mid reset alu", {alu_a, alu_op}, 0);
    check("mid reset req_ready", req_ready, 2'b00);
    q.delete();
    m_ptr = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) step();
    issue(0, 1, 2, 4'd2);
    issue(1, 3, 4, 4'd2);
    drain();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!p_v[i] && $urandom_range(0, 2) == 0) begin
          logic [31:0] a, b;
          logic [3:0]  op;
          a = $urandom;
          b = $urandom_range(0, 3) == 0 ? a : $urandom;
          case ($urandom_range(0, 4))
            0: op = 4'd0;
            1: op = 4'd1;
            2: op = 4'd2;
            3: op = 4'd6;
            default: op = 4'($urandom);
          endcase
          issue(i, a, b, op);
        end
      rsp_ready = 2'($urandom);
      step();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
